// File: rtl/truth_table_sweeper_if.sv
// Handshake and stimulus/result bundle for truth_table_sweeper.
// The master side drives start, expected and f; the slave side is the sweeper.
interface truth_table_sweeper_if;
    logic        start;
    logic [15:0] expected;
    logic        f;
    logic        a;
    logic        b;
    logic        c;
    logic        d;
    logic        busy;
    logic        done;
    logic [15:0] tt;
    logic [15:0] mismatch;
    logic [4:0]  err_cnt;
    logic        pass;

    modport master (
        output start, expected, f,
        input  a, b, c, d, busy, done, tt, mismatch, err_cnt, pass
    );

    modport slave (
        input  start, expected, f,
        output a, b, c, d, busy, done, tt, mismatch, err_cnt, pass
    );
endinterface

// File: rtl/truth_table_sweeper.sv
// Steps {a,b,c,d} through all 16 vectors, samples f and grades it against expected.
// Optional SWEEP_STOP_ON_FAIL_EN ends the sweep at the first mismatching sample.
module truth_table_sweeper #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    truth_table_sweeper_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_idx;
    logic [7:0]  r_hold;
    logic [15:0] r_exp;
    logic [15:0] r_tt;
    logic [15:0] r_mm;
    logic [4:0]  r_err;
    logic        r_pass;
    logic        w_miss;
    logic        w_stop;
    logic        w_drive;
    logic [4:0]  w_err_nxt;

    assign w_miss    = bus.f ^ r_exp[r_idx];
    assign w_err_nxt = r_err + 5'(w_miss);
    assign w_drive   = (r_state == S_SETTLE) || (r_state == S_SAMPLE);

`ifdef SWEEP_STOP_ON_FAIL_EN
    assign w_stop = (r_idx == 4'd15) || w_miss;
`else
    assign w_stop = (r_idx == 4'd15);
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:   if (bus.start) w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_hold == HOLD_LAST) w_state_nxt = S_SAMPLE;
            S_SAMPLE: w_state_nxt = w_stop ? S_DONE : S_SETTLE;
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // pass is written on the edge into DONE so it is valid alongside done
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx  <= '0;
            r_hold <= '0;
            r_exp  <= '0;
            r_tt   <= '0;
            r_mm   <= '0;
            r_err  <= '0;
            r_pass <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_exp  <= bus.expected;
                        r_tt   <= '0;
                        r_mm   <= '0;
                        r_err  <= '0;
                        r_pass <= 1'b0;
                        r_idx  <= '0;
                        r_hold <= '0;
                    end
                end
                S_SETTLE: r_hold <= r_hold + 8'd1;
                S_SAMPLE: begin
                    r_tt[r_idx] <= bus.f;
                    r_mm[r_idx] <= w_miss;
                    r_err       <= w_err_nxt;
                    if (w_stop) begin
                        r_pass <= (w_err_nxt == 5'd0);
                    end else begin
                        r_idx  <= r_idx + 4'd1;
                        r_hold <= '0;
                    end
                end
                S_DONE: begin
                    r_idx  <= '0;
                    r_hold <= '0;
                end
                default: ;
            endcase
        end
    end

    assign bus.a        = w_drive & r_idx[3];
    assign bus.b        = w_drive & r_idx[2];
    assign bus.c        = w_drive & r_idx[1];
    assign bus.d        = w_drive & r_idx[0];
    assign bus.busy     = w_drive;
    assign bus.done     = (r_state == S_DONE);
    assign bus.tt       = r_tt;
    assign bus.mismatch = r_mm;
    assign bus.err_cnt  = r_err;
    assign bus.pass     = r_pass;
endmodule
